// File: rtl/imem_responder_pkg.sv
// Shared definitions for the iDEA instruction-memory responder.
// Holds the default geometry (IM_ADDR_WIDTH, DATA_WIDTH) and the FSM state encoding.
package imem_responder_pkg;

    localparam int unsigned IM_ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        IMEM_IDLE  = 2'd0,
        IMEM_LOAD  = 2'd1,
        IMEM_FLUSH = 2'd2,
        IMEM_RUN   = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, written so that it maps onto a block RAM.
// Ports:
//   clk   - clock
//   we    - write enable (write has priority; read returns the old word)
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data
module imem_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetch with a 1-cycle registered read and
// owns program loading over a valid/ready stream, holding the core in reset
// until a load completes.
// Optional feature macro: IMEM_PARITY_EN (adds a parity bit per word and par_err_o).
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   pc_i / inst_o           - fetch address in, instruction word out (0 unless running)
//   core_rst_o              - high while no valid program is resident
//   load_req_i, load_len_i  - start-of-load pulse and word count
//   load_valid_i/_data_i    - host word stream
//   load_ready_o            - word accepted this cycle
//   load_done_o             - one-cycle pulse when the core is released
//   par_err_o               - sticky parity error (IMEM_PARITY_EN only)
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = IM_ADDR_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              core_rst_o,
    input  logic              load_req_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o
`ifdef IMEM_PARITY_EN
    ,
    output logic              par_err_o
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH = CNT_W'(1) << ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int unsigned RAM_W = DATA_W + 1;
`else
    localparam int unsigned RAM_W = DATA_W;
`endif

    imem_state_e       state, state_nxt;
    logic [ADDR_W-1:0] waddr, waddr_nxt;
    logic [ADDR_W:0]   remain, remain_nxt;
    logic [ADDR_W:0]   len_clamped;
    logic              we;
    logic              ram_we;
    logic              run, run_nxt;
    logic              core_rst_nxt, ready_nxt, done_nxt;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;

    assign len_clamped = (load_len_i > DEPTH) ? DEPTH : load_len_i;

    // Next-state, counters and registered-output precompute.
    // A load request restarts from any state and takes priority over a word
    // presented in the same cycle (that word is dropped).
    always_comb begin
        state_nxt    = state;
        waddr_nxt    = waddr;
        remain_nxt   = remain;
        we           = 1'b0;

        if (load_req_i) begin
            waddr_nxt  = '0;
            remain_nxt = len_clamped;
            state_nxt  = (len_clamped == '0) ? IMEM_FLUSH : IMEM_LOAD;
        end else begin
            case (state)
                IMEM_IDLE: state_nxt = IMEM_IDLE;
                IMEM_LOAD: begin
                    if (load_valid_i) begin
                        we         = 1'b1;
                        waddr_nxt  = waddr + ADDR_W'(1);
                        remain_nxt = remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            state_nxt = IMEM_FLUSH;
                        end
                    end
                end
                IMEM_FLUSH: state_nxt = IMEM_RUN;
                IMEM_RUN:   state_nxt = IMEM_RUN;
                default:    state_nxt = IMEM_IDLE;
            endcase
        end

        core_rst_nxt = (state_nxt != IMEM_RUN);
        ready_nxt    = (state_nxt == IMEM_LOAD);
        done_nxt     = (state == IMEM_FLUSH) && (state_nxt == IMEM_RUN);
        run_nxt      = (state_nxt == IMEM_RUN);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IMEM_IDLE;
            waddr        <= '0;
            remain       <= '0;
            core_rst_o   <= 1'b1;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b0;
            run          <= 1'b0;
        end else begin
            state        <= state_nxt;
            waddr        <= waddr_nxt;
            remain       <= remain_nxt;
            core_rst_o   <= core_rst_nxt;
            load_ready_o <= ready_nxt;
            load_done_o  <= done_nxt;
            run          <= run_nxt;
        end
    end

    // Write address wins the single port; no writes happen in RUN.
    assign ram_we   = we & ~rst;
    assign ram_addr = ram_we ? waddr : pc_i;

`ifdef IMEM_PARITY_EN
    // Stored parity bit makes the whole RAM word even parity.
    assign ram_wdata = {^load_data_i, load_data_i};
`else
    assign ram_wdata = load_data_i;
`endif

    imem_ram #(
        .ADDR_W(ADDR_W),
        .WIDTH (RAM_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Outside RUN the fetch stage sees a NOP, never a stale word.
    assign inst_o = run ? ram_rdata[DATA_W-1:0] : '0;

`ifdef IMEM_PARITY_EN
    logic par_hit;
    logic par_sticky;

    // Flag shows in the same cycle the bad word appears on inst_o.
    assign par_hit = run & (^ram_rdata);

    always_ff @(posedge clk) begin
        if (rst || load_req_i) begin
            par_sticky <= 1'b0;
        end else if (par_hit) begin
            par_sticky <= 1'b1;
        end
    end

    assign par_err_o = par_sticky | par_hit;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// loads, checked against an array model of program memory.
module tb_imem_responder;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic          core_rst;
    logic          load_req;
    logic [AW:0]   load_len;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
`ifdef IMEM_PARITY_EN
    logic          par_err;
`endif

    imem_responder #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc),
        .inst_o      (inst),
        .core_rst_o  (core_rst),
        .load_req_i  (load_req),
        .load_len_i  (load_len),
        .load_valid_i(load_valid),
        .load_data_i (load_data),
        .load_ready_o(load_ready),
        .load_done_o (load_done)
`ifdef IMEM_PARITY_EN
        ,
        .par_err_o   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the program memory must hold.
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];

    // Directed data / valid patterns for the next load (random when empty).
    logic [DW-1:0] dir_words[$];
    bit            dir_valid[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, ".core_rst"}, DW'(core_rst), DW'(1));
        check({tag, ".inst"}, inst, '0);
        check({tag, ".ready"}, DW'(load_ready), DW'(0));
        check({tag, ".done"}, DW'(load_done), DW'(0));
    endtask

    // One complete load: request, stream words, FLUSH, then the done pulse.
    task automatic do_load(input int len);
        int clamped;
        int accepted;
        int k;
        bit v;
        logic [DW-1:0] d;
        clamped    = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        load_req   = 1'b1;
        load_len   = (AW+1)'(len);
        load_valid = 1'b0;
        pc         = AW'($urandom);
        tick();
        load_req   = 1'b0;
        accepted   = 0;
        k          = 0;
        while (accepted < clamped) begin
            check("load.ready", DW'(load_ready), DW'(1));
            check("load.core_rst", DW'(core_rst), DW'(1));
            check("load.inst", inst, '0);
            v = (k < dir_valid.size()) ? dir_valid[k] : ($urandom_range(3) != 0);
            d = (accepted < dir_words.size()) ? dir_words[accepted] : $urandom;
            load_valid = v;
            load_data  = d;
            pc         = AW'($urandom);
            tick();
            k++;
            if (v) begin
                ref_mem[accepted]   = d;
                ref_known[accepted] = 1'b1;
                accepted++;
            end
        end
        load_valid = 1'b0;
        check_held("flush");
        tick();
        check("done.pulse", DW'(load_done), DW'(1));
        check("done.core_rst", DW'(core_rst), DW'(0));
        check("done.ready", DW'(load_ready), DW'(0));
        dir_words.delete();
        dir_valid.delete();
    endtask

    task automatic do_read(input int addr);
        pc = AW'(addr);
        tick();
        check("run.core_rst", DW'(core_rst), DW'(0));
        check("run.done", DW'(load_done), DW'(0));
        if (ref_known[addr]) begin
            check($sformatf("read[%0d]", addr), inst, ref_mem[addr]);
        end
    endtask

    task automatic push_word(input int idx, input logic [DW-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        ref_mem[idx]   = d;
        ref_known[idx] = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        pc         = '0;
        load_req   = 1'b0;
        load_len   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        tick();
        tick();
        check_held("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc = AW'($urandom);
            tick();
            check_held("idle");
        end

        // Back-to-back length-4 load, then read the third word.
        dir_words.push_back(32'h1111_1111);
        dir_words.push_back(32'h2222_2222);
        dir_words.push_back(32'h3333_3333);
        dir_words.push_back(32'h4444_4444);
        for (int i = 0; i < 4; i++) dir_valid.push_back(1'b1);
        do_load(4);
        do_read(2);
        check("pc2.stable", inst, 32'h3333_3333);
        do_read(0);
        do_read(3);

        // Stalling host: exactly three writes, word 3 untouched.
        dir_valid.push_back(1'b1);
        dir_valid.push_back(1'b0);
        dir_valid.push_back(1'b0);
        dir_valid.push_back(1'b1);
        dir_valid.push_back(1'b0);
        dir_valid.push_back(1'b1);
        do_load(3);
        for (int a = 0; a < 4; a++) do_read(a);
        check("keep.word3", inst, 32'h4444_4444);

        // Zero-length load leaves memory unchanged.
        do_load(0);
        for (int a = 0; a < 4; a++) do_read(a);

        // Reload from RUN with a single word.
        dir_words.push_back(32'hDEAD_BEEF);
        dir_valid.push_back(1'b1);
        do_load(1);
        do_read(0);
        check("reload.word0", inst, 32'hDEAD_BEEF);
        do_read(1);

        // Over-length request clamps to full depth.
        do_load(20);
        for (int a = 0; a < int'(DEPTH); a++) do_read(a);

        // Reset mid-load aborts but keeps the words already written.
        load_req = 1'b1;
        load_len = (AW+1)'(5);
        tick();
        load_req = 1'b0;
        push_word(0, $urandom);
        push_word(1, $urandom);
        rst = 1'b1;
        tick();
        check_held("abort");
        rst = 1'b0;
        tick();
        check_held("abort.idle");
        do_load(0);
        do_read(0);
        do_read(1);
        do_read(2);

        // Request while loading restarts at address 0.
        load_req = 1'b1;
        load_len = (AW+1)'(6);
        tick();
        load_req = 1'b0;
        push_word(0, $urandom);
        push_word(1, $urandom);
        push_word(2, $urandom);
        do_load(2);
        for (int a = 0; a < 4; a++) do_read(a);

        // Randomized loads and reads.
        for (int it = 0; it < 8; it++) begin
            do_load(int'($urandom_range(0, 20)));
            for (int r = 0; r < 4; r++) do_read(int'($urandom_range(0, DEPTH - 1)));
        end

`ifdef IMEM_PARITY_EN
        dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
        do_read(0);
        check("par.clean", DW'(par_err), DW'(0));
        pc = AW'(1);
        tick();
        check("par.set", DW'(par_err), DW'(1));
        pc = AW'(0);
        tick();
        check("par.sticky", DW'(par_err), DW'(1));
        do_load(0);
        check("par.cleared", DW'(par_err), DW'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
